// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan path.
package seg_pkg;

   localparam int         DIGITS  = 4;
   localparam logic [3:0] SEL_OFF = 4'b1111;

   typedef logic [3:0] nibble_t;
   typedef logic [1:0] dptr_t;

   // Active-low one-hot select for digit p.
   function automatic logic [3:0] sel_of(input dptr_t p);
      return ~(4'b0001 << p);
   endfunction

   function automatic nibble_t nibble_at(input logic [15:0] v, input dptr_t p);
      nibble_t n;
      case (p)
         2'd0:    n = v[3:0];
         2'd1:    n = v[7:4];
         2'd2:    n = v[11:8];
         default: n = v[15:12];
      endcase
      return n;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value handshake between a producer and the display scan stage.
interface seg_scan_ctrl_if;

   logic [15:0] value;
   logic        value_vld;
   logic        value_rdy;

   modport master (output value, output value_vld, input  value_rdy);
   modport slave  (input  value, input  value_vld, output value_rdy);

endinterface

// File: rtl/seg_tick_gen.sv
// Divides the system clock down to a one-cycle scan tick every CLK_HZ/SCAN_HZ cycles.
module seg_tick_gen #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1_000
) (
   input  logic clk_100MHz,
   input  logic rst,
   output logic tick
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] tick_cnt;

   // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk_100MHz) begin
      if (!rst)                 tick_cnt <= '0;
      else if (tick_cnt == LAST) tick_cnt <= '0;
      else                      tick_cnt <= tick_cnt + CW'(1);
   end

   assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit scan stage: frame-aligned value commit, pointer stepping and anode select.
// Optional LEADING_ZERO_BLANK_EN turns off leading zero digits (digit 0 always shown).
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1_000
) (
   input  logic             clk_100MHz,
   input  logic             rst,
   seg_scan_ctrl_if.slave   value_if,
   input  logic             blank,
   output nibble_t          digit_code,
   output logic [3:0]       seg_sel,
   output logic             frame_done
);

   logic        tick;
   dptr_t       digit_ptr;
   dptr_t       ptr_nxt;
   logic [15:0] shadow;
   logic [15:0] shadow_nxt;
   logic [15:0] pending;
   logic        pending_full;
   logic        accept;
   logic        wrap;
   logic        commit;
   logic [3:0]  lz_mask;

   seg_tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .SCAN_HZ (SCAN_HZ)
   ) u_tick (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .tick       (tick)
   );

   assign value_if.value_rdy = ~pending_full;
   assign accept             = value_if.value_vld & ~pending_full;
   assign wrap               = tick && (digit_ptr == 2'd3);
   // Commit looks only at the pending register held before this edge, so a value
   // accepted on the wrap edge itself waits for the following frame.
   assign commit             = wrap && pending_full;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      ptr_nxt    = digit_ptr;
      shadow_nxt = shadow;
      if (tick)   ptr_nxt    = digit_ptr + 2'd1;
      if (commit) shadow_nxt = pending;
   end

`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin
      lz_mask    = '0;
      lz_mask[3] = (shadow_nxt[15:12] == 4'h0);
      lz_mask[2] = lz_mask[3] && (shadow_nxt[11:8] == 4'h0);
      lz_mask[1] = lz_mask[2] && (shadow_nxt[7:4]  == 4'h0);
   end
`else
   assign lz_mask = '0;
`endif

   always_ff @(posedge clk_100MHz) begin
      if (!rst) begin
         digit_ptr    <= '0;
         shadow       <= '0;
         pending      <= '0;
         pending_full <= 1'b0;
      end else begin
         digit_ptr <= ptr_nxt;
         shadow    <= shadow_nxt;
         if (accept) begin
            pending      <= value_if.value;
            pending_full <= 1'b1;
         end else if (commit) begin
            pending_full <= 1'b0;
         end
      end
   end

   // Select is refreshed every cycle so blank acts on the next edge; it only
   // changes digit position when the pointer does.
   always_ff @(posedge clk_100MHz) begin
      if (!rst) begin
         digit_code <= 4'h0;
         seg_sel    <= SEL_OFF;
         frame_done <= 1'b0;
      end else begin
         frame_done <= wrap;
         if (tick) digit_code <= nibble_at(shadow_nxt, ptr_nxt);
         seg_sel <= blank ? SEL_OFF : (sel_of(ptr_nxt) | lz_mask);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_HZ=1000, SCAN_HZ=100 (one digit step every 10 cycles).
module tb_seg_scan_ctrl;
   import seg_pkg::*;

   typedef struct {
      int          edge_n;
      int          digit;
      logic [15:0] sh;
      logic [3:0]  code;
      logic        fd;
      logic        rdy;
   } vec_t;

   logic       clk_100MHz = 1'b0;
   logic       rst;
   logic       blank;
   nibble_t    digit_code;
   logic [3:0] seg_sel;
   logic       frame_done;

   int checks   = 0;
   int failures = 0;
   int edge_n   = 0;

   seg_scan_ctrl_if bus ();

   seg_scan_ctrl #(
      .CLK_HZ  (1000),
      .SCAN_HZ (100)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .value_if   (bus),
      .blank      (blank),
      .digit_code (digit_code),
      .seg_sel    (seg_sel),
      .frame_done (frame_done)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   function automatic logic [3:0] sel_exp(input int d, input logic [15:0] sh);
      logic [3:0] s;
      s = ~(4'b0001 << d);
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && (sh >> (4 * d)) == 16'h0) s = 4'b1111;
`endif
      return s;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] sel, input logic [3:0] code,
                             input logic fd, input logic rdy);
      check($sformatf("%s seg_sel", tag),    {12'h0, seg_sel},    {12'h0, sel});
      check($sformatf("%s digit_code", tag), {12'h0, digit_code}, {12'h0, code});
      check($sformatf("%s frame_done", tag), {15'h0, frame_done}, {15'h0, fd});
      check($sformatf("%s value_rdy", tag),  {15'h0, bus.value_rdy}, {15'h0, rdy});
   endtask

   // Advance to just after rising edge n (counted from reset release), sampled at the falling edge.
   task automatic run_to(input int n);
      while (edge_n < n) begin
         @(posedge clk_100MHz);
         edge_n++;
      end
      @(negedge clk_100MHz);
   endtask

   task automatic at(input int n, input int d, input logic [15:0] sh, input logic [3:0] code,
                     input logic fd, input logic rdy);
      run_to(n);
      check_outs($sformatf("e%0d", n), sel_exp(d, sh), code, fd, rdy);
   endtask

   vec_t tbl[10];

   initial begin
      // Idle scan after reset: digit steps every 10 edges, wrap every 40.
      tbl[0] = '{1,  0, 16'h0, 4'h0, 1'b0, 1'b1};
      tbl[1] = '{9,  0, 16'h0, 4'h0, 1'b0, 1'b1};
      tbl[2] = '{10, 1, 16'h0, 4'h0, 1'b0, 1'b1};
      tbl[3] = '{20, 2, 16'h0, 4'h0, 1'b0, 1'b1};
      tbl[4] = '{30, 3, 16'h0, 4'h0, 1'b0, 1'b1};
      tbl[5] = '{39, 3, 16'h0, 4'h0, 1'b0, 1'b1};
      tbl[6] = '{40, 0, 16'h0, 4'h0, 1'b1, 1'b1};
      tbl[7] = '{41, 0, 16'h0, 4'h0, 1'b0, 1'b1};
      tbl[8] = '{79, 3, 16'h0, 4'h0, 1'b0, 1'b1};
      tbl[9] = '{80, 0, 16'h0, 4'h0, 1'b1, 1'b1};

      rst           = 1'b0;
      blank         = 1'b0;
      bus.value     = 16'h0;
      bus.value_vld = 1'b0;
      repeat (3) @(posedge clk_100MHz);
      @(negedge clk_100MHz);
      check_outs("reset", 4'b1111, 4'h0, 1'b0, 1'b1);
      rst    = 1'b1;
      edge_n = 0;

      for (int i = 0; i < 10; i++)
         at(tbl[i].edge_n, tbl[i].digit, tbl[i].sh, tbl[i].code, tbl[i].fd, tbl[i].rdy);

      // Mid-frame accept of 1234, committed at the E120 wrap.
      run_to(85);
      bus.value     = 16'h1234;
      bus.value_vld = 1'b1;
      at(86, 0, 16'h0, 4'h0, 1'b0, 1'b0);
      bus.value_vld = 1'b0;
      at(119, 3, 16'h0,    4'h0, 1'b0, 1'b0);
      at(120, 0, 16'h1234, 4'h4, 1'b1, 1'b1);
      at(130, 1, 16'h1234, 4'h3, 1'b0, 1'b1);
      at(140, 2, 16'h1234, 4'h2, 1'b0, 1'b1);
      at(150, 3, 16'h1234, 4'h1, 1'b0, 1'b1);

      // value_vld held: ABCD accepted, 5678 waits until value_rdy returns.
      bus.value     = 16'hABCD;
      bus.value_vld = 1'b1;
      at(151, 3, 16'h1234, 4'h1, 1'b0, 1'b0);
      bus.value     = 16'h5678;
      at(159, 3, 16'h1234, 4'h1, 1'b0, 1'b0);
      at(160, 0, 16'hABCD, 4'hD, 1'b1, 1'b1);
      at(161, 0, 16'hABCD, 4'hD, 1'b0, 1'b0);
      bus.value_vld = 1'b0;
      at(170, 1, 16'hABCD, 4'hC, 1'b0, 1'b0);
      at(180, 2, 16'hABCD, 4'hB, 1'b0, 1'b0);
      at(190, 3, 16'hABCD, 4'hA, 1'b0, 1'b0);
      at(200, 0, 16'h5678, 4'h8, 1'b1, 1'b1);
      at(210, 1, 16'h5678, 4'h7, 1'b0, 1'b1);
      at(230, 3, 16'h5678, 4'h5, 1'b0, 1'b1);

      // Accept exactly on the wrap-tick edge: shown one frame later.
      run_to(239);
      bus.value     = 16'hF0E1;
      bus.value_vld = 1'b1;
      at(240, 0, 16'h5678, 4'h8, 1'b1, 1'b0);
      bus.value_vld = 1'b0;
      at(250, 1, 16'h5678, 4'h7, 1'b0, 1'b0);
      at(270, 3, 16'h5678, 4'h5, 1'b0, 1'b0);
      at(280, 0, 16'hF0E1, 4'h1, 1'b1, 1'b1);
      at(290, 1, 16'hF0E1, 4'hE, 1'b0, 1'b1);
      at(300, 2, 16'hF0E1, 4'h0, 1'b0, 1'b1);
      at(310, 3, 16'hF0E1, 4'hF, 1'b0, 1'b1);

      // Three-cycle blank pulse in the middle of digit 3.
      at(313, 3, 16'hF0E1, 4'hF, 1'b0, 1'b1);
      blank = 1'b1;
      run_to(314);
      check("blank e314 seg_sel", {12'h0, seg_sel}, 16'h000F);
      run_to(315);
      check("blank e315 seg_sel", {12'h0, seg_sel}, 16'h000F);
      run_to(316);
      check("blank e316 seg_sel", {12'h0, seg_sel}, 16'h000F);
      blank = 1'b0;
      at(317, 3, 16'hF0E1, 4'hF, 1'b0, 1'b1);
      at(319, 3, 16'hF0E1, 4'hF, 1'b0, 1'b1);
      at(320, 0, 16'hF0E1, 4'h1, 1'b1, 1'b1);

      // Reset pulse with a value pending: everything returns to reset state.
      run_to(325);
      bus.value     = 16'h0070;
      bus.value_vld = 1'b1;
      at(326, 0, 16'hF0E1, 4'h1, 1'b0, 1'b0);
      bus.value_vld = 1'b0;
      run_to(333);
      rst = 1'b0;
      run_to(334);
      check_outs("midreset", 4'b1111, 4'h0, 1'b0, 1'b1);
      rst = 1'b1;
      at(335, 0, 16'h0, 4'h0, 1'b0, 1'b1);
      at(343, 0, 16'h0, 4'h0, 1'b0, 1'b1);
      at(344, 1, 16'h0, 4'h0, 1'b0, 1'b1);
      at(374, 0, 16'h0, 4'h0, 1'b1, 1'b1);

      // Leading-zero case: 0070 shows digits 1 and 0 only when the option is built in.
      run_to(375);
      bus.value     = 16'h0070;
      bus.value_vld = 1'b1;
      at(376, 0, 16'h0, 4'h0, 1'b0, 1'b0);
      bus.value_vld = 1'b0;
      at(414, 0, 16'h0070, 4'h0, 1'b1, 1'b1);
      at(424, 1, 16'h0070, 4'h7, 1'b0, 1'b1);
      at(434, 2, 16'h0070, 4'h0, 1'b0, 1'b1);
      at(444, 3, 16'h0070, 4'h0, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
